// File: rtl/knn_controller.sv
// Sequencer for one distance_calculator: walks the training set chunk by chunk,
// keeps the K nearest (distance, type) pairs in ascending order and votes the class.
module knn_controller #(
  parameter int W         = 16,
  parameter int TYPE_W    = 4,
  parameter int NUM_TRAIN = 64,
  parameter int CHUNKS    = 4,
  parameter int K         = 5,
  parameter int NUM_TYPES = 4,
  parameter int TIMEOUT   = 4096,
  localparam int SW   = (NUM_TRAIN > 1) ? $clog2(NUM_TRAIN) : 1,
  localparam int CW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [SW-1:0]     sample_idx,
  output logic [CW-1:0]     chunk_idx,
  output logic              dc_ready,
  input  logic              dc_data_request,
  input  logic              dc_done,
  input  logic [W-1:0]      dc_distance,
  input  logic [TYPE_W-1:0] dc_type,
  output logic              busy,
  output logic              done,
  output logic [TYPE_W-1:0] class_out,
  output logic              error
);

  localparam int CNTW = $clog2(K + 1);
  localparam int TMW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, KICK, WAIT, INSERT, VOTE, FINISH} state_t;

  state_t state, state_nx;

  logic [TMW-1:0]    wait_cnt;
  logic [W-1:0]      new_dist;
  logic [TYPE_W-1:0] new_type;
  logic [W-1:0]      slot_dist [K];
  logic [TYPE_W-1:0] slot_type [K];
  logic [K-1:0]      slot_vld;
  logic [W-1:0]      ins_dist  [K];
  logic [TYPE_W-1:0] ins_type  [K];
  logic [K-1:0]      ins_vld;
  logic [K-1:0]      le;
  logic [K:0]        le_ext;
  logic [TYPE_W-1:0] vote_t;
  logic [TYPE_W-1:0] best_type;
  logic [CNTW-1:0]   best_cnt;
  logic [CNTW-1:0]   vote_cnt;
  logic              last_sample;
  logic              last_type;
  logic              vote_wins;

  assign last_sample = (sample_idx == SW'(NUM_TRAIN - 1));
  assign last_type   = (vote_t == TYPE_W'(NUM_TYPES - 1));
  assign vote_wins   = (vote_cnt > best_cnt);

  assign dc_ready = (state == KICK);
  assign done     = (state == FINISH);
  assign busy     = (state != IDLE) && (state != FINISH);

  // A slot is "at or before" the new entry when valid and not farther; invalid slots act as +inf.
  always_comb begin
    le_ext = '0;
    for (int i = 0; i < K; i++) begin
      le[i] = slot_vld[i] && (slot_dist[i] <= new_dist);
    end
    le_ext = {le, 1'b1};
    for (int i = 0; i < K; i++) begin
      ins_dist[i] = slot_dist[i];
      ins_type[i] = slot_type[i];
      ins_vld[i]  = slot_vld[i];
      if (!le[i]) begin
        if (le_ext[i]) begin
          ins_dist[i] = new_dist;
          ins_type[i] = new_type;
          ins_vld[i]  = 1'b1;
        end else begin
          ins_dist[i] = slot_dist[(i == 0) ? 0 : i - 1];
          ins_type[i] = slot_type[(i == 0) ? 0 : i - 1];
          ins_vld[i]  = slot_vld[(i == 0) ? 0 : i - 1];
        end
      end
    end
  end

  always_comb begin
    vote_cnt = '0;
    for (int i = 0; i < K; i++) begin
      if (slot_vld[i] && (slot_type[i] == vote_t)) vote_cnt = vote_cnt + CNTW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = FETCH;
      FETCH:  state_nx = KICK;
      KICK:   state_nx = WAIT;
      WAIT: begin
        if (dc_done)                             state_nx = INSERT;
        else if (dc_data_request)                state_nx = FETCH;
        else if (wait_cnt == TMW'(TIMEOUT - 1))  state_nx = IDLE;
      end
      INSERT: state_nx = last_sample ? VOTE : FETCH;
      VOTE:   if (last_type) state_nx = FINISH;
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sample_idx <= '0;
      chunk_idx  <= '0;
      wait_cnt   <= '0;
      slot_vld   <= '0;
      vote_t     <= '0;
      best_type  <= '0;
      best_cnt   <= '0;
      class_out  <= '0;
      error      <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          sample_idx <= '0;
          chunk_idx  <= '0;
          slot_vld   <= '0;
          class_out  <= '0;
          error      <= 1'b0;
        end
        KICK: wait_cnt <= '0;
        WAIT: begin
          if (dc_done) begin
            wait_cnt <= wait_cnt;
          end else if (dc_data_request) begin
            // The calculator owns the chunk count, so an extra request just wraps.
            chunk_idx <= (chunk_idx == CW'(CHUNKS - 1)) ? '0 : chunk_idx + CW'(1);
          end else if (wait_cnt == TMW'(TIMEOUT - 1)) begin
            error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TMW'(1);
          end
        end
        INSERT: begin
          slot_vld <= ins_vld;
          if (last_sample) begin
            vote_t    <= '0;
            best_type <= '0;
            best_cnt  <= '0;
          end else begin
            sample_idx <= sample_idx + SW'(1);
            chunk_idx  <= '0;
          end
        end
        VOTE: begin
          vote_t <= vote_t + TYPE_W'(1);
          if (vote_wins) begin
            best_type <= vote_t;
            best_cnt  <= vote_cnt;
          end
          if (last_type) class_out <= vote_wins ? vote_t : best_type;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers carry no reset; validity is tracked by slot_vld.
  always_ff @(posedge clk) begin
    if (state == WAIT && dc_done) begin
      new_dist <= dc_distance;
      new_type <= dc_type;
    end
    if (state == INSERT) begin
      for (int i = 0; i < K; i++) begin
        slot_dist[i] <= ins_dist[i];
        slot_type[i] <= ins_type[i];
      end
    end
  end

endmodule
